// File: rtl/seven_segment_decoder.sv
// Receive-side monitor for a 2-digit multiplexed active-low seven-segment bus.
// Rebuilds the displayed hex byte and flags bad patterns and a stalled display.
// Optional build macro SEVSEG_DEC_CHANGE_ONLY_EN: a word equal to the current one does not pulse word_valid.
module seven_segment_decoder #(
   parameter int WIDTH   = 8,
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 2_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       seg,
   input  logic [7:0]       anode_activate,
   output logic [WIDTH-1:0] word,
   output logic             word_valid,
   output logic             pattern_err,
   output logic             stale
);

   localparam int CW = $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
   localparam logic [CW-1:0] CAP_AT    = CW'(SETTLE - 1);
   localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

   logic [14:0]      sync1_q, sync2_q, prev_q;
   logic [CW-1:0]    stab_q, stab_d;
   logic             cap;
   logic [7:0]       anode_s;
   logic [6:0]       lit_s;
   logic             glyph_hit;
   logic [3:0]       glyph_nib;
   logic [3:0]       hold_h_q, hold_h_d, hold_l_q, hold_l_d;
   logic             flag_h_q, flag_h_d, flag_l_q, flag_l_d;
   logic             publish, pulse, perr_d;
   logic [WIDTH-1:0] new_word, word_q, word_d;
   logic             wv_q, perr_q;
   logic [TW-1:0]    to_q, to_d;
   logic             stale_q, stale_d;

   assign anode_s = sync2_q[14:7];
   assign lit_s   = ~sync2_q[6:0];

   // Capture fires on the single cycle the stability count steps onto SETTLE.
   always_comb begin
      stab_d = stab_q;
      cap    = 1'b0;
      if (sync2_q != prev_q) begin
         stab_d = '0;
      end else if (stab_q != SETTLE_C) begin
         stab_d = stab_q + CW'(1);
         cap    = (stab_q == CAP_AT);
      end
   end

   always_comb begin
      glyph_hit = 1'b1;
      glyph_nib = 4'h0;
      case (lit_s)
         7'h7E:   glyph_nib = 4'h0;
         7'h30:   glyph_nib = 4'h1;
         7'h6D:   glyph_nib = 4'h2;
         7'h79:   glyph_nib = 4'h3;
         7'h33:   glyph_nib = 4'h4;
         7'h5B:   glyph_nib = 4'h5;
         7'h5F:   glyph_nib = 4'h6;
         7'h70:   glyph_nib = 4'h7;
         7'h7F:   glyph_nib = 4'h8;
         7'h7B:   glyph_nib = 4'h9;
         7'h77:   glyph_nib = 4'hA;
         7'h1F:   glyph_nib = 4'hB;
         7'h4E:   glyph_nib = 4'hC;
         7'h3D:   glyph_nib = 4'hD;
         7'h4F:   glyph_nib = 4'hE;
         7'h47:   glyph_nib = 4'hF;
         default: glyph_hit = 1'b0;
      endcase
   end

   always_comb begin
      hold_h_d = hold_h_q;
      hold_l_d = hold_l_q;
      flag_h_d = flag_h_q;
      flag_l_d = flag_l_q;
      perr_d   = 1'b0;
      publish  = 1'b0;
      if (cap) begin
         case (anode_s)
            8'hFE: begin
               if (glyph_hit) begin
                  hold_h_d = glyph_nib;
                  flag_h_d = 1'b1;
               end else begin
                  flag_h_d = 1'b0;
                  perr_d   = 1'b1;
               end
            end
            8'hFD: begin
               if (glyph_hit) begin
                  hold_l_d = glyph_nib;
                  flag_l_d = 1'b1;
               end else begin
                  flag_l_d = 1'b0;
                  perr_d   = 1'b1;
               end
            end
            8'hFF: begin
            end
            default: begin
               perr_d   = 1'b1;
               flag_h_d = 1'b0;
               flag_l_d = 1'b0;
            end
         endcase
      end
      if (flag_h_d && flag_l_d) begin
         publish  = 1'b1;
         flag_h_d = 1'b0;
         flag_l_d = 1'b0;
      end
   end

   assign new_word = WIDTH'({hold_h_d, hold_l_d});
   assign word_d   = publish ? new_word : word_q;

`ifdef SEVSEG_DEC_CHANGE_ONLY_EN
   logic first_q;

   assign pulse = publish && (first_q || (new_word != word_q));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         first_q <= 1'b1;
      end else if (publish) begin
         first_q <= 1'b0;
      end
   end
`else
   assign pulse = publish;
`endif

   // Any publish (pulsed or not) restarts the stale timer and wins over expiry.
   always_comb begin
      to_d    = to_q;
      stale_d = stale_q;
      if (publish) begin
         to_d    = '0;
         stale_d = 1'b0;
      end else if (to_q != TIMEOUT_C) begin
         to_d = to_q + TW'(1);
         if (to_d == TIMEOUT_C) begin
            stale_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         prev_q   <= '0;
         stab_q   <= '0;
         hold_h_q <= '0;
         hold_l_q <= '0;
         flag_h_q <= 1'b0;
         flag_l_q <= 1'b0;
         word_q   <= '0;
         wv_q     <= 1'b0;
         perr_q   <= 1'b0;
         to_q     <= '0;
         stale_q  <= 1'b1;
      end else begin
         sync1_q  <= {anode_activate, seg};
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         stab_q   <= stab_d;
         hold_h_q <= hold_h_d;
         hold_l_q <= hold_l_d;
         flag_h_q <= flag_h_d;
         flag_l_q <= flag_l_d;
         word_q   <= word_d;
         wv_q     <= pulse;
         perr_q   <= perr_d;
         to_q     <= to_d;
         stale_q  <= stale_d;
      end
   end

   assign word        = word_q;
   assign word_valid  = wv_q;
   assign pattern_err = perr_q;
   assign stale       = stale_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: cycle-level reference model plus directed scenarios
// (capture, glitch, bad glyph, bad anode, timeout, repeat word, reset mid-pair).
module tb_seven_segment_decoder;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 100;
`ifdef SEVSEG_DEC_CHANGE_ONLY_EN
   localparam bit CHANGE_ONLY = 1'b1;
`else
   localparam bit CHANGE_ONLY = 1'b0;
`endif
   localparam logic [6:0] GLY [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                       7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] seg = 7'h7F;
   logic [7:0] anode_activate = 8'hFF;
   logic [7:0] word;
   logic       word_valid, pattern_err, stale;

   int vectors = 0;
   int miscompares = 0;

   seven_segment_decoder #(.WIDTH(8), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .seg(seg), .anode_activate(anode_activate),
      .word(word), .word_valid(word_valid), .pattern_err(pattern_err), .stale(stale)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at cycle", name, act, exp);
      end
   endtask

   // Reference model: a capture happens when the bus value seen SETTLE+1 cycles in a row
   // (after the two sync stages) differs from what preceded it.
   logic [14:0] samp [SETTLE+4];
   logic [3:0]  m_h, m_l;
   logic [7:0]  m_word;
   bit          m_fh, m_fl, m_first, m_never, m_wv, m_perr;
   int          m_since;
   int          cyc = 0;

   function automatic bit m_settled();
      for (int i = 3; i <= SETTLE + 2; i++)
         if (samp[i] != samp[2]) return 1'b0;
      return samp[SETTLE+3] != samp[2];
   endfunction

   task automatic m_capture(input logic [14:0] v);
      logic [7:0] a;
      logic [6:0] lit;
      logic [7:0] nw;
      bit         hit;
      logic [3:0] nib;
      a   = v[14:7];
      lit = ~v[6:0];
      hit = 1'b0;
      nib = 4'h0;
      for (int i = 0; i < 16; i++)
         if (GLY[i] == lit) begin hit = 1'b1; nib = 4'(i); end
      if (a == 8'hFE) begin
         if (hit) begin m_h = nib; m_fh = 1'b1; end
         else begin m_fh = 1'b0; m_perr = 1'b1; end
      end else if (a == 8'hFD) begin
         if (hit) begin m_l = nib; m_fl = 1'b1; end
         else begin m_fl = 1'b0; m_perr = 1'b1; end
      end else if (a != 8'hFF) begin
         m_perr = 1'b1; m_fh = 1'b0; m_fl = 1'b0;
      end
      if (m_fh && m_fl) begin
         nw      = {m_h, m_l};
         m_wv    = !CHANGE_ONLY || m_first || (nw != m_word);
         m_word  = nw;
         m_first = 1'b0;
         m_never = 1'b0;
         m_since = 0;
         m_fh    = 1'b0;
         m_fl    = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      m_wv   = 1'b0;
      m_perr = 1'b0;
      if (!reset) begin
         for (int i = 0; i < SETTLE + 4; i++) samp[i] = '0;
         m_h = 0; m_l = 0; m_fh = 0; m_fl = 0;
         m_word = 0; m_first = 1; m_never = 1; m_since = 0;
      end else begin
         for (int i = SETTLE + 3; i > 0; i--) samp[i] = samp[i-1];
         samp[0] = {anode_activate, seg};
         m_since++;
         if (m_settled()) m_capture(samp[2]);
      end
   end

   bit chk_en = 1'b0;
   int wv_cnt = 0, perr_cnt = 0, wv_cyc = -1, rise_cyc = -1;
   bit stale_prev = 1'b1;

   always @(negedge clk) begin
      if (chk_en && reset) begin
         cmp("word", word, m_word);
         cmp("word_valid", word_valid, m_wv);
         cmp("pattern_err", pattern_err, m_perr);
         cmp("stale", stale, (m_never || m_since >= TIMEOUT) ? 1 : 0);
         if (word_valid) begin wv_cnt++; wv_cyc = cyc; end
         if (pattern_err) perr_cnt++;
         if (stale && !stale_prev) rise_cyc = cyc;
         stale_prev = stale;
      end
   end

   int chg_cyc = 0;

   task automatic apply(input logic [7:0] a, input logic [6:0] s, input int n);
      anode_activate = a;
      seg            = s;
      chg_cyc        = cyc;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_counts();
      wv_cnt   = 0;
      perr_cnt = 0;
   endtask

   task automatic check_reset_values(input string tag);
      cmp({tag, "_word"}, word, 8'h00);
      cmp({tag, "_wv"}, word_valid, 0);
      cmp({tag, "_perr"}, pattern_err, 0);
      cmp({tag, "_stale"}, stale, 1);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      reset          = 1'b0;
      anode_activate = 8'hFF;
      seg            = 7'h7F;
      #2;
      check_reset_values("rst_mid");
      repeat (3) @(posedge clk);
      #1;
      reset      = 1'b1;
      stale_prev = 1'b1;
   endtask

   int pub_cyc;

   initial begin
      #2 reset = 1'b0;
      @(negedge clk);
      check_reset_values("rst_init");
      @(posedge clk);
      #1;
      reset  = 1'b1;
      chk_en = 1'b1;
      apply(8'hFF, 7'h7F, 10);

      // Capture 8'h13 and measure latency of the completing digit
      clr_counts();
      apply(8'hFE, ~7'h30, 10);
      apply(8'hFD, ~7'h79, 10);
      cmp("t1_word", word, 8'h13);
      cmp("t1_pulses", wv_cnt, 1);
      cmp("t1_perr", perr_cnt, 0);
      cmp("t1_latency", wv_cyc - chg_cyc, SETTLE + 3);
      cmp("t1_stale", stale, 0);
      pub_cyc = wv_cyc;

      // Timeout: blank display, stale rises exactly TIMEOUT cycles after publish
      apply(8'hFF, 7'h7F, 120);
      cmp("t5_stale_delay", rise_cyc - pub_cyc, TIMEOUT);
      cmp("t5_stale_set", stale, 1);
      clr_counts();
      apply(8'hFE, ~7'h6D, 10);
      apply(8'hFD, ~7'h30, 10);
      cmp("t5_word", word, 8'h21);
      cmp("t5_stale_clr", stale, 0);
      cmp("t5_pulses", wv_cnt, 1);

      // Glitch shorter than SETTLE
      apply(8'hFF, 7'h7F, 10);
      clr_counts();
      apply(8'hFE, ~7'h5B, 3);
      apply(8'hFF, 7'h7F, 12);
      cmp("t2_pulses", wv_cnt, 0);
      cmp("t2_perr", perr_cnt, 0);
      cmp("t2_word", word, 8'h21);

      // Bad glyph
      clr_counts();
      apply(8'hFE, ~7'h01, 10);
      apply(8'hFF, 7'h7F, 10);
      cmp("t3_perr", perr_cnt, 1);
      cmp("t3_pulses", wv_cnt, 0);
      cmp("t3_word", word, 8'h21);

      // Bad anode, then L-only capture
      clr_counts();
      apply(8'hFC, ~7'h30, 10);
      apply(8'hFD, ~7'h79, 10);
      apply(8'hFF, 7'h7F, 10);
      cmp("t4_perr", perr_cnt, 1);
      cmp("t4_pulses", wv_cnt, 0);
      cmp("t4_word", word, 8'h21);

      // Repeat word after a clean reset
      pulse_reset();
      clr_counts();
      for (int r = 0; r < 2; r++) begin
         apply(8'hFE, ~7'h30, 10);
         apply(8'hFD, ~7'h79, 10);
         apply(8'hFF, 7'h7F, 10);
      end
      cmp("t6_pulses", wv_cnt, CHANGE_ONLY ? 1 : 2);
      cmp("t6_word", word, 8'h13);

      // Reset between H and L discards the half pair
      apply(8'hFE, ~7'h4E, 10);
      pulse_reset();
      clr_counts();
      apply(8'hFD, ~7'h79, 10);
      apply(8'hFF, 7'h7F, 10);
      cmp("t6r_pulses", wv_cnt, 0);
      cmp("t6r_word", word, 8'h00);
      cmp("t6r_stale", stale, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
